// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial BCD adder sequencer: drives one external single-digit BCD adder
// per clock, least-significant digit first, and collects the packed result.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a_bcd,
  input  logic [4*DIGITS-1:0]   b_bcd,
  input  logic                  cin,
  output logic [3:0]            add_a,
  output logic [3:0]            add_b,
  output logic                  add_cin,
  input  logic [3:0]            add_sum,
  input  logic                  add_cout,
  output logic [4*DIGITS-1:0]   sum_bcd,
  output logic                  cout,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   idx_q;
  logic            carry_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic [W-1:0]    sum_q;
  logic            cout_q;
  logic            done_q;
  logic            err_q;
  logic [3:0]      a_dig_s;
  logic [3:0]      b_dig_s;

  // True when any 4-bit digit of the packed operand is outside 0..9.
  function automatic logic has_bad_digit(input logic [W-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      bad = bad | (v[4*i +: 4] > 4'd9);
    end
    return bad;
  endfunction

  // Select the operand digits addressed by the running index.
  always_comb begin
    a_dig_s = 4'd0;
    b_dig_s = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      a_dig_s = a_dig_s | ({4{idx_q == IW'(i)}} & a_q[4*i +: 4]);
      b_dig_s = b_dig_s | ({4{idx_q == IW'(i)}} & b_q[4*i +: 4]);
    end
  end

  // Digit-adder operands are only live while running; quiet zeros otherwise.
  always_comb begin
    add_a   = 4'd0;
    add_b   = 4'd0;
    add_cin = 1'b0;
    case (state_q)
      RUN: begin
        add_a   = a_dig_s;
        add_b   = b_dig_s;
        add_cin = carry_q;
      end
      default: begin
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
      end
    endcase
  end

  // Sequencer state, operand capture, carry chain and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= {IW{1'b0}};
      carry_q <= 1'b0;
      a_q     <= {W{1'b0}};
      b_q     <= {W{1'b0}};
      sum_q   <= {W{1'b0}};
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a_bcd;
            b_q     <= b_bcd;
            carry_q <= cin;
            idx_q   <= {IW{1'b0}};
            err_q   <= 1'b0;
            if (has_bad_digit(a_bcd) || has_bad_digit(b_bcd)) begin
              err_q   <= 1'b1;
              sum_q   <= {W{1'b0}};
              cout_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
              sum_q[4*i +: 4] <= add_sum;
            end
          end
          carry_q <= add_cout;
          if (idx_q == LAST_IDX) begin
            cout_q  <= add_cout;
            done_q  <= 1'b1;
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sum_bcd = sum_q;
  assign cout    = cout_q;
  assign done    = done_q;
  assign err     = err_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Directed bench for bcd_serial_add_ctrl with a behavioural digit adder on add_*.
module tb_bcd_serial_add_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] a_bcd;
  logic [15:0] b_bcd;
  logic        cin;
  logic [3:0]  add_a;
  logic [3:0]  add_b;
  logic        add_cin;
  logic [3:0]  add_sum;
  logic        add_cout;
  logic [15:0] sum_bcd;
  logic        cout;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_bcd(a_bcd), .b_bcd(b_bcd), .cin(cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .sum_bcd(sum_bcd), .cout(cout), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-digit decimal adder the controller time-shares.
  always_comb begin
    logic [4:0] raw;
    raw = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};
    if (raw > 5'd9) begin
      add_sum  = 4'(raw - 5'd10);
      add_cout = 1'b1;
    end else begin
      add_sum  = raw[3:0];
      add_cout = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one addition, wait for done, check latency, busy span and results,
  // then step into the following idle cycle.
  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic [15:0] es, input logic ec,
                         input logic ee, input int ecyc, input bit hold_start);
    int cyc;
    int bcnt;
    a_bcd = a;
    b_bcd = b;
    cin   = ci;
    start = 1'b1;
    tick();
    if (hold_start) begin
      a_bcd = 16'h9999;
      b_bcd = 16'h8888;
      cin   = 1'b1;
    end else begin
      start = 1'b0;
    end
    cyc  = 1;
    bcnt = busy ? 1 : 0;
    if (ee) chk($sformatf("%s_add_a_idle", tag), {28'd0, add_a}, 32'd0);
    while (!done && cyc < 20) begin
      tick();
      cyc++;
      bcnt += busy ? 1 : 0;
    end
    start = 1'b0;
    chk($sformatf("%s_done_cycle", tag), cyc, ecyc);
    chk($sformatf("%s_busy_cycles", tag), bcnt, ecyc);
    chk($sformatf("%s_sum", tag), {16'd0, sum_bcd}, {16'd0, es});
    chk($sformatf("%s_cout", tag), {31'd0, cout}, {31'd0, ec});
    chk($sformatf("%s_err", tag), {31'd0, err}, {31'd0, ee});
    tick();
    chk($sformatf("%s_idle_busy", tag), {31'd0, busy}, 32'd0);
    chk($sformatf("%s_idle_done", tag), {31'd0, done}, 32'd0);
    chk($sformatf("%s_hold_sum", tag), {16'd0, sum_bcd}, {16'd0, es});
  endtask

  initial begin
    int dseen;
    rst   = 1'b1;
    start = 1'b0;
    a_bcd = 16'h0;
    b_bcd = 16'h0;
    cin   = 1'b0;
    tick();
    tick();
    chk("rst_sum",  {16'd0, sum_bcd}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err",  {31'd0, err}, 32'd0);
    chk("rst_add_a", {28'd0, add_a}, 32'd0);
    rst = 1'b0;
    tick();

    run_add("basic",   16'h0025, 16'h0007, 1'b0, 16'h0032, 1'b0, 1'b0, 5, 1'b0);
    run_add("ripple",  16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 5, 1'b0);
    run_add("cin",     16'h5678, 16'h4321, 1'b1, 16'h0000, 1'b1, 1'b0, 5, 1'b0);
    run_add("b2b",     16'h0002, 16'h0005, 1'b0, 16'h0007, 1'b0, 1'b0, 5, 1'b0);
    run_add("badbcd",  16'h00A1, 16'h0003, 1'b0, 16'h0000, 1'b0, 1'b1, 1, 1'b0);
    run_add("after_err", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 5, 1'b0);
    run_add("ignore_start", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 5, 1'b1);

    // Reset in the middle of a run discards the partial result.
    a_bcd = 16'h4444;
    b_bcd = 16'h4444;
    cin   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_sum",  {16'd0, sum_bcd}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    dseen = 0;
    for (int i = 0; i < 6; i++) begin
      dseen += done ? 1 : 0;
      tick();
    end
    chk("midrst_no_done", dseen, 0);

    run_add("post_rst", 16'h0009, 16'h0009, 1'b0, 16'h0018, 1'b0, 1'b0, 5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
